// File: rtl/seq_hit_window_counter_pkg.sv
// Shared definitions for the 1011 detector and its hit window counter.
// State encodings and the detector pattern live here so both units agree.
package seq_hit_window_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_hit_window_counter_if.sv
// Result handshake bundle between the window counter and its consumer.
// master drives start/hit/rdy; slave is the counter.
interface seq_hit_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             hit;
  logic             rdy;
  logic             vld;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             busy;

  modport master (
    output start, hit, rdy,
    input  vld, cnt, ovf, busy
  );

  modport slave (
    input  start, hit, rdy,
    output vld, cnt, ovf, busy
  );
endinterface

// File: rtl/seq_hit_window_counter_sat.sv
// Saturating up-counter used as the hit accumulator.
// sat_hit flags an increment request arriving while already full.
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  logic [W-1:0] r_q;
  logic         w_full;

  assign w_full  = &r_q;
  assign sat_hit = inc & w_full;
  assign q       = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !w_full) begin
      r_q <= r_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_hit_window_counter.sv
// Counts detector hits over a WIN_LEN-cycle window opened by start,
// then holds the saturating count and overflow flag until consumed.
module seq_hit_window_counter
  import seq_hit_window_counter_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int CNT_W   = 8
) (
  input logic   clk,
  input logic   rst_n,
  seq_hit_if.slave bus
);

  localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WIN_W-1:0] LAST = WIN_W'(WIN_LEN - 1);

  state_t           r_state;
  logic [WIN_W-1:0] r_timer;
  logic             r_ovf_acc;
  logic             r_vld;
  logic             r_ovf;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic             w_clr;
  logic             w_inc;
  logic             w_last;
  logic             w_sat_hit;
  logic [CNT_W-1:0] w_acc;
  logic [CNT_W-1:0] w_fin;

  assign w_clr  = (r_state == ST_IDLE) & bus.start;
  assign w_inc  = (r_state == ST_COUNT) & bus.hit;
  assign w_last = (r_timer == LAST);
  // Final cycle's hit is folded in as the result is latched.
  assign w_fin  = w_acc + CNT_W'(w_inc & ~(&w_acc));

  seq_sat_counter #(
    .W(CNT_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .inc     (w_inc),
    .q       (w_acc),
    .sat_hit (w_sat_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_ovf_acc <= 1'b0;
      r_vld     <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state   <= ST_COUNT;
            r_timer   <= '0;
            r_ovf_acc <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (w_sat_hit) r_ovf_acc <= 1'b1;
          if (w_last) begin
            r_cnt   <= w_fin;
            r_ovf   <= r_ovf_acc | w_sat_hit;
            r_vld   <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_vld && bus.rdy) begin
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vld  = r_vld;
  assign bus.cnt  = r_cnt;
  assign bus.ovf  = r_ovf;
  assign bus.busy = r_busy;

endmodule
